// File: rtl/dma_burst_mem_responder.sv
// Memory-side responder for the DMA burst read/write channel pair: serves read
// bursts from, and absorbs write bursts into, a 2^ADDR_WIDTH x 32-bit word array.
module dma_burst_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           rd_req_addr,
    input  logic [4:0]            rd_req_len,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic [31:0]           rd_rdata,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    input  logic [31:0]           wr_req_addr,
    input  logic [4:0]            wr_req_len,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [31:0]           wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  busy,
    output logic                  err,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [31:0]           dbg_rdata
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA} state_t;
    typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

    state_t                state;
    grant_t                last_grant;
    logic [ADDR_WIDTH-1:0] idx;
    logic [4:0]            len;
    logic [4:0]            count;
    logic [3:0]            wait_cnt;
    logic [31:0]           mem [2**ADDR_WIDTH];

    logic rd_grant;
    logic wr_grant;
    logic end_of_burst;

    // Under contention the channel not served last time wins.
    assign rd_grant     = rd_req_valid && (!wr_req_valid || last_grant == GRANT_WR);
    assign wr_grant     = wr_req_valid && (!rd_req_valid || last_grant == GRANT_RD);
    assign rd_req_ready = (state == IDLE) && rd_grant;
    assign wr_req_ready = (state == IDLE) && wr_grant;

    assign end_of_burst = (count == len);
    assign rd_valid     = (state == RD_DATA);
    assign rd_last      = (state == RD_DATA) && end_of_burst;
    assign rd_rdata     = mem[idx];
    assign wr_ready     = (state == WR_DATA);
    assign busy         = (state != IDLE);
    assign dbg_rdata    = mem[dbg_addr];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_WR;
            err        <= 1'b0;
            idx        <= '0;
            len        <= '0;
            count      <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req_ready) begin
                        idx        <= rd_req_addr[ADDR_WIDTH+1:2];
                        len        <= rd_req_len;
                        count      <= '0;
                        last_grant <= GRANT_RD;
                        if (RD_LAT == 0) begin
                            state <= RD_DATA;
                        end else begin
                            wait_cnt <= 4'(RD_LAT - 1);
                            state    <= RD_WAIT;
                        end
                    end else if (wr_req_ready) begin
                        idx        <= wr_req_addr[ADDR_WIDTH+1:2];
                        len        <= wr_req_len;
                        count      <= '0;
                        last_grant <= GRANT_WR;
                        state      <= WR_DATA;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RD_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RD_DATA: begin
                    if (rd_ready) begin
                        idx   <= idx + 1'b1;
                        count <= count + 5'd1;
                        if (end_of_burst) begin
                            state <= IDLE;
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_valid) begin
                        idx   <= idx + 1'b1;
                        count <= count + 5'd1;
                        // The length decides where the burst ends; wr_last is only checked.
                        if (wr_last != end_of_burst) begin
                            err <= 1'b1;
                        end
                        if (end_of_burst) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the word array is deliberately not reset; contents survive rst and
    // a plain clocked write lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (state == WR_DATA && wr_valid) begin
            mem[idx] <= wr_data;
        end
    end

    // Byte-offset and aliased upper address bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_req_addr[31:ADDR_WIDTH+2], rd_req_addr[1:0],
                                wr_req_addr[31:ADDR_WIDTH+2], wr_req_addr[1:0]};

endmodule

// File: tb/tb_dma_burst_mem_responder.sv
// Directed self-checking bench for dma_burst_mem_responder: arbitration, burst
// data/latency, stalls, wrap/alias addressing, wr_last error and mid-burst reset.
module tb_dma_burst_mem_responder;

    localparam int ADDR_WIDTH = 10;
    localparam int RD_LAT     = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [31:0]           rd_req_addr;
    logic [4:0]            rd_req_len;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [31:0]           rd_rdata;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  rd_ready;
    logic [31:0]           wr_req_addr;
    logic [4:0]            wr_req_len;
    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [31:0]           wr_data;
    logic                  wr_valid;
    logic                  wr_last;
    logic                  wr_ready;
    logic                  busy;
    logic                  err;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [31:0]           dbg_rdata;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [31:0] exp_data [32];

    dma_burst_mem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_rdata     (rd_rdata),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .rd_ready     (rd_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_len   (wr_req_len),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .busy         (busy),
        .err          (err),
        .dbg_addr     (dbg_addr),
        .dbg_rdata    (dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_rd(input logic [31:0] addr, input logic [4:0] len);
        bit ok = 1'b0;
        rd_req_addr  = addr;
        rd_req_len   = len;
        rd_req_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = rd_req_ready;
            tick();
        end
        rd_req_valid = 1'b0;
        check("rd_accept", 32'(ok), 32'd1);
    endtask

    task automatic accept_wr(input logic [31:0] addr, input logic [4:0] len);
        bit ok = 1'b0;
        wr_req_addr  = addr;
        wr_req_len   = len;
        wr_req_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = wr_req_ready;
            tick();
        end
        wr_req_valid = 1'b0;
        check("wr_accept", 32'(ok), 32'd1);
    endtask

    // Called right after the write accept edge; beat i carries base+i.
    task automatic run_wr(input int len, input logic [31:0] base, input int last_at);
        for (int i = 0; i <= len; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            wr_last  = (i == last_at);
            check("wr_ready", 32'(wr_ready), 32'd1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check("wr_end_ready", 32'(wr_ready), 32'd0);
        check("wr_end_busy", 32'(busy), 32'd0);
    endtask

    // Called right after the read accept edge. stall gives rd_ready 1,0,0,1,0,0...
    // abort_at >= 0 pulses rst while that beat is presented.
    task automatic run_rd(input int len, input bit stall, input bit check_data, input int abort_at);
        int          lat = 1;
        int          beat = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        bit          done = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        while (!rd_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("rd_latency", 32'(lat), 32'(RD_LAT + 1));
        while (!done && cyc < 200) begin
            if (beat == abort_at) begin
                rst      = 1'b1;
                rd_ready = 1'b1;
                tick();
                rst      = 1'b0;
                rd_ready = 1'b0;
                check("abort_rd_valid", 32'(rd_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                return;
            end
            check("rd_valid", 32'(rd_valid), 32'd1);
            if (stalled) begin
                check("stall_data", rd_rdata, prev_data);
                check("stall_last", 32'(rd_last), 32'(prev_last));
            end
            rd_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (rd_ready) begin
                if (check_data) begin
                    check($sformatf("rd_data[%0d]", beat), rd_rdata, exp_data[beat]);
                end
                check($sformatf("rd_last[%0d]", beat), 32'(rd_last), 32'(beat == len));
                if (beat == len || rd_last) begin
                    done = 1'b1;
                end
                beat++;
                stalled = 1'b0;
            end else begin
                prev_data = rd_rdata;
                prev_last = rd_last;
                stalled   = 1'b1;
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        check("rd_beats", 32'(beat), 32'(len + 1));
        check("rd_end_valid", 32'(rd_valid), 32'd0);
        check("rd_end_busy", 32'(busy), 32'd0);
    endtask

    task automatic contend(input string tag);
        rd_req_addr  = 32'h0000_0100;
        rd_req_len   = 5'd1;
        wr_req_addr  = 32'h0000_0200;
        wr_req_len   = 5'd1;
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        #1;
        check({tag, "_rd_grant"}, 32'(rd_req_ready), 32'd1);
        check({tag, "_wr_hold"}, 32'(wr_req_ready), 32'd0);
        tick();
        rd_req_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_wr_wait"}, 32'(wr_req_ready), 32'd0);
        run_rd(1, 1'b0, 1'b0, -1);
        #1;
        check({tag, "_wr_grant"}, 32'(wr_req_ready), 32'd1);
        tick();
        wr_req_valid = 1'b0;
        run_wr(1, 32'h11, 1);
    endtask

    task automatic check_dbg(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check($sformatf("dbg[%0d]", a), dbg_rdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0; rd_ready = 1'b0;
        wr_req_addr = '0; wr_req_len = '0; wr_req_valid = 1'b0;
        wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0; dbg_addr = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Contention right after reset grants read, then the next pair alternates back to read.
        contend("arb1");
        contend("arb2");
        check("arb_err", 32'(err), 32'd0);

        // Write then read back 0xA0..0xA7 at 0x100, first with rd_ready high, then stalling.
        accept_wr(32'h0000_0100, 5'd7);
        run_wr(7, 32'hA0, 7);
        for (int i = 0; i < 8; i++) exp_data[i] = 32'hA0 + 32'(i);
        accept_rd(32'h0000_0100, 5'd7);
        run_rd(7, 1'b0, 1'b1, -1);
        check("rw_err", 32'(err), 32'd0);
        accept_rd(32'h0000_0100, 5'd7);
        run_rd(7, 1'b1, 1'b1, -1);

        // Misplaced wr_last: flag sets and sticks, but all eight words still land.
        accept_wr(32'h0000_0300, 5'd7);
        run_wr(7, 32'hB0, 3);
        check("err_set", 32'(err), 32'd1);
        for (int i = 0; i < 8; i++) check_dbg(ADDR_WIDTH'(32'hC0 + 32'(i)), 32'hB0 + 32'(i));

        // Index wrap at the top of the array and aliasing of upper address bits.
        accept_wr(32'h0000_0FF8, 5'd3);
        run_wr(3, 32'd1, 3);
        check_dbg(10'd1022, 32'd1);
        check_dbg(10'd1023, 32'd2);
        check_dbg(10'd0, 32'd3);
        check_dbg(10'd1, 32'd4);
        for (int i = 0; i < 4; i++) exp_data[i] = 32'd1 + 32'(i);
        accept_rd(32'h0000_1FF8, 5'd3);
        run_rd(3, 1'b0, 1'b1, -1);
        check("err_sticky", 32'(err), 32'd1);

        // Reset during beat 4 of an 8-beat read aborts cleanly; array is untouched.
        for (int i = 0; i < 8; i++) exp_data[i] = 32'hA0 + 32'(i);
        accept_rd(32'h0000_0100, 5'd7);
        run_rd(7, 1'b0, 1'b1, 3);
        check("abort_err_clr", 32'(err), 32'd0);
        accept_rd(32'h0000_0100, 5'd7);
        run_rd(7, 1'b0, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule

// File: doc/dma_burst_mem_responder.md
Name: dma_burst_mem_responder

Overview:
- Memory-side responder for the DMA burst read/write channel pair. It serves read bursts from an internal word array and absorbs write bursts into it.
- Used as the memory model/endpoint behind the DMA engine. One transaction is in flight at a time. Read and write requests are arbitrated round-robin.
- A debug port gives bench/CPU-side inspection of array contents.

Parameters:
- ADDR_WIDTH, 10, word-index bits; array holds 2^ADDR_WIDTH 32-bit words.
- RD_LAT, 2, idle cycles between read-request accept and first read beat; legal range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_req_addr  in  32  read burst byte address
- rd_req_len  in  5  beats minus one
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted this cycle
- rd_rdata  out  32  read beat data
- rd_valid  out  1  read beat valid
- rd_last  out  1  final read beat
- rd_ready  in  1  initiator accepts read beat
- wr_req_addr  in  32  write burst byte address
- wr_req_len  in  5  beats minus one
- wr_req_valid  in  1  write request valid
- wr_req_ready  out  1  write request accepted this cycle
- wr_data  in  32  write beat data
- wr_valid  in  1  write beat valid
- wr_last  in  1  initiator marks final write beat
- wr_ready  out  1  responder accepts write beat
- busy  out  1  state != IDLE
- err  out  1  sticky wr_last/length mismatch flag
- dbg_addr  in  ADDR_WIDTH  debug word index
- dbg_rdata  out  32  mem[dbg_addr], combinational

Behaviour:
- **States:** IDLE, RD_WAIT, RD_DATA, WR_DATA.
- **Reset:** state=IDLE; all ready/valid outputs 0; rd_last=0; busy=0; err=0; last_grant=WRITE, so the first contention grants read. Array contents are NOT reset. Reset mid-burst aborts the transaction: outputs deassert in the cycle after the reset edge, and partial writes already committed stay in the array.
- **Address mapping:**
  - word index = addr[ADDR_WIDTH+1:2].
  - addr[1:0] is ignored, and upper bits are ignored (aliasing).
  - The index increments by 1 per beat, modulo 2^ADDR_WIDTH (wraps).
- **Arbitration in IDLE (request ready signals are combinational):**
  - Only rd_req_valid high: rd_req_ready=1.
  - Only wr_req_valid high: wr_req_ready=1.
  - Both high: grant the channel opposite last_grant.
  - The accept edge is valid&&ready. On accept, latch index, len, beat count=0, and update last_grant.
  - Request ready signals are 0 in all other states.
- **Read path:**
  - RD_LAT=0: go directly to RD_DATA. Otherwise go to RD_WAIT for exactly RD_LAT cycles.
  - The first rd_valid is therefore high RD_LAT+1 cycles after the accept edge.
  - In RD_DATA: rd_valid=1, rd_rdata=mem[idx] (asynchronous array read), rd_last=(count==len).
  - A beat transfers on rd_valid&&rd_ready; then idx++ and count++.
  - With rd_ready held low, rd_rdata and rd_last hold stable.
  - Throughput is 1 beat/cycle with rd_ready high.
  - A transfer with rd_last → IDLE; rd_valid is 0 the next cycle.
- **Write path:**
  - In WR_DATA: wr_ready=1.
  - On wr_valid&&wr_ready: mem[idx]<=wr_data, idx++, count++.
  - The beat where count==len ends the burst → IDLE, and wr_ready drops the next cycle.
  - Length is authoritative. If wr_last != (count==len) on any accepted beat, set err=1 (sticky until rst). The burst still completes after exactly len+1 beats.
- **Back-to-back:** a new request can be accepted in the first IDLE cycle after completion, giving a minimum 1-cycle gap.
- **dbg_rdata:** always reflects the current array contents. A write lands the cycle after its beat edge.

Test Plan:
- Write 0x100, len 7, data 0xA0..0xA7; then read 0x100, len 7, rd_ready=1, RD_LAT=2 → first rd_valid 3 cycles after accept; 8 consecutive beats 0xA0..0xA7; rd_last only on beat 8; busy drops after it; err=0.
- Same read with rd_ready toggling 1,0,0,1,... → rd_rdata/rd_last stable during stalls; exactly 8 beats delivered, none duplicated or skipped.
- Both req_valid asserted the cycle after reset → read granted first, write accepted after read completes. Next simultaneous pair → read granted again (alternation holds).
- Write len 7 with wr_last asserted on beat 3 and not on beat 8 → err=1 and stays 1; all 8 words written (check via dbg_addr).
- ADDR_WIDTH=10, write 0xFF8 len 3 data 1,2,3,4 → dbg shows mem[1022]=1, mem[1023]=2, mem[0]=3, mem[1]=4; read 0x1FF8 (alias) returns the same sequence.
- rst pulsed during beat 4 of an 8-beat read → rd_valid=0 and busy=0 next cycle; a subsequent read of the same address returns unchanged data.
